// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipelined ARM-style control unit: decode, E/M/W control registers, flags
// Conditional execution is enabled by defining COND_EXEC_EN; otherwise every instruction executes.
module pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlags,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [1:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemtoRegE,
  output logic        MemWriteM,
  output logic        RegWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        PCWrPendingF
);

  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;

  assign cond_d  = InstrD[19:16];
  assign op_d    = InstrD[15:14];
  assign funct_d = InstrD[13:8];
  assign rd_d    = InstrD[3:0];

  logic       reg_write_d;
  logic       mem_to_reg_d;
  logic       mem_write_d;
  logic       branch_d;
  logic       alu_src_d;
  logic [1:0] alu_control_d;
  logic [1:0] flag_write_d;
  logic       pcs_d;
  logic       dp_d;
  logic       add_sub_d;

  always_comb begin
    reg_write_d   = 1'b0;
    mem_to_reg_d  = 1'b0;
    mem_write_d   = 1'b0;
    branch_d      = 1'b0;
    alu_src_d     = 1'b0;
    alu_control_d = 2'b00;
    RegSrcD       = 2'b00;
    case (op_d)
      2'b00: begin
        alu_src_d   = funct_d[5];
        reg_write_d = 1'b1;
        case (funct_d[4:1])
          4'b0100: alu_control_d = 2'b00;
          4'b0010: alu_control_d = 2'b01;
          4'b0000: alu_control_d = 2'b10;
          4'b1100: alu_control_d = 2'b11;
          default: begin
            alu_control_d = 2'b00;
            reg_write_d   = 1'b0;
          end
        endcase
      end
      2'b01: begin
        alu_src_d = 1'b1;
        if (funct_d[0]) begin
          mem_to_reg_d = 1'b1;
          reg_write_d  = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          RegSrcD[1]  = 1'b1;
        end
      end
      2'b10: begin
        branch_d   = 1'b1;
        alu_src_d  = 1'b1;
        RegSrcD[0] = 1'b1;
      end
      default: ;
    endcase
  end

  assign dp_d         = (op_d == 2'b00);
  assign add_sub_d    = (funct_d[4:1] == 4'b0100) | (funct_d[4:1] == 4'b0010);
  assign flag_write_d = {funct_d[0] & dp_d, funct_d[0] & dp_d & add_sub_d};
  assign pcs_d        = ((rd_d == 4'hf) & reg_write_d) | branch_d;
  assign ImmSrcD      = op_d;

  // Decode -> Execute; a flush squashes only the fields that cause side effects
  logic       reg_write_e;
  logic       mem_to_reg_e;
  logic       mem_write_e;
  logic       pcs_e;
  logic       branch_e;
  logic       alu_src_e;
  logic [1:0] alu_control_e;
  logic [1:0] flag_write_e;
  logic [3:0] cond_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      mem_write_e   <= 1'b0;
      pcs_e         <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      alu_control_e <= 2'b00;
      flag_write_e  <= 2'b00;
      cond_e        <= 4'h0;
    end else begin
      reg_write_e   <= reg_write_d & ~FlushE;
      mem_write_e   <= mem_write_d & ~FlushE;
      pcs_e         <= pcs_d & ~FlushE;
      branch_e      <= branch_d & ~FlushE;
      flag_write_e  <= flag_write_d & {2{~FlushE}};
      mem_to_reg_e  <= mem_to_reg_d;
      alu_src_e     <= alu_src_d;
      alu_control_e <= alu_control_d;
      cond_e        <= cond_d;
    end
  end

  logic [3:0] flags_e;
  logic       cond_ex_e;

`ifdef COND_EXEC_EN
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_e;

  always_comb begin
    cond_ex_e = 1'b0;
    case (cond_e)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~flag_c | flag_z;
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end
`else
  assign cond_ex_e = 1'b1;
  logic unused_cond;
  assign unused_cond = ^{cond_e, flags_e};
`endif

  // Flags commit at the edge the setter leaves Execute, so the next instruction sees them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_e <= 4'h0;
    end else begin
      if (flag_write_e[1] & cond_ex_e) flags_e[3:2] <= ALUFlags[3:2];
      if (flag_write_e[0] & cond_ex_e) flags_e[1:0] <= ALUFlags[1:0];
    end
  end

  logic reg_write_m;
  logic mem_to_reg_m;
  logic mem_write_m;
  logic pcs_m;
  logic reg_write_w;
  logic mem_to_reg_w;
  logic pcs_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      pcs_m        <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pcs_w        <= 1'b0;
    end else begin
      reg_write_m  <= reg_write_e & cond_ex_e;
      mem_write_m  <= mem_write_e & cond_ex_e;
      pcs_m        <= pcs_e & cond_ex_e;
      mem_to_reg_m <= mem_to_reg_e;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pcs_w        <= pcs_m;
    end
  end

  logic unused_instr;
  assign unused_instr = ^InstrD[7:4];

  assign ALUSrcE      = alu_src_e;
  assign ALUControlE  = alu_control_e;
  assign MemtoRegE    = mem_to_reg_e;
  assign BranchTakenE = branch_e & cond_ex_e;
  assign MemWriteM    = mem_write_m;
  assign RegWriteM    = reg_write_m;
  assign RegWriteW    = reg_write_w;
  assign MemtoRegW    = mem_to_reg_w;
  assign PCSrcW       = pcs_w;
  assign PCWrPendingF = pcs_d | pcs_e | pcs_m;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - randomized and directed bench for pipeline_controller
// Works with or without COND_EXEC_EN defined.
module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemtoRegE;
  logic        MemWriteM;
  logic        RegWriteM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        PCWrPendingF;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COND_EXEC_EN
  localparam bit COND_ON = 1'b1;
`else
  localparam bit COND_ON = 1'b0;
`endif

  localparam logic [19:0] NOP    = {4'he, 2'b11, 6'b000000, 4'h0, 4'h0};
  localparam logic [19:0] ADD_R1 = {4'he, 2'b00, 6'b001000, 4'h0, 4'h1};
  localparam logic [19:0] SUBS   = {4'he, 2'b00, 6'b000101, 4'h0, 4'h2};
  localparam logic [19:0] BEQ    = {4'h0, 2'b10, 6'b100000, 4'h0, 4'h0};
  localparam logic [19:0] LDR_PC = {4'he, 2'b01, 6'b011001, 4'h0, 4'hf};
  localparam logic [19:0] STR    = {4'he, 2'b01, 6'b011000, 4'h0, 4'h3};
  localparam logic [19:0] ADDNE  = {4'h1, 2'b00, 6'b001000, 4'h0, 4'h4};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-instruction control bundle as the spec describes it
  typedef struct packed {
    logic       rw, mr, mw, pcs, br, as;
    logic [1:0] ac, fw;
    logic [3:0] cond;
  } ctl_t;

  ctl_t       e_s, m_s, w_s;
  logic [3:0] flags_s;

  function automatic ctl_t decode(input logic [19:0] ins);
    ctl_t       c;
    logic [1:0] op;
    logic [5:0] fn;
    c    = '0;
    op   = ins[15:14];
    fn   = ins[13:8];
    c.cond = ins[19:16];
    if (op == 2'd0) begin
      c.as = fn[5];
      c.rw = 1'b1;
      case (fn[4:1])
        4'd4:    c.ac = 2'd0;
        4'd2:    c.ac = 2'd1;
        4'd0:    c.ac = 2'd2;
        4'd12:   c.ac = 2'd3;
        default: c.rw = 1'b0;
      endcase
      c.fw = {fn[0], fn[0] && (fn[4:1] == 4'd4 || fn[4:1] == 4'd2)};
    end else if (op == 2'd1) begin
      c.as = 1'b1;
      if (fn[0]) begin c.mr = 1'b1; c.rw = 1'b1; end
      else c.mw = 1'b1;
    end else if (op == 2'd2) begin
      c.br = 1'b1;
      c.as = 1'b1;
    end
    c.pcs = (c.rw && ins[3:0] == 4'hf) || c.br;
    return c;
  endfunction

  // Conditions come in complementary pairs: even code tests, odd code inverts
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return COND_ON ? (base ^ cond[0]) : 1'b1;
  endfunction

  task automatic check_all();
    ctl_t d;
    logic cx;
    d  = decode(InstrD);
    cx = cond_ok(e_s.cond, flags_s);
    check("RegSrcD", RegSrcD, {InstrD[15:14] == 2'd1 && !InstrD[8], InstrD[15:14] == 2'd2});
    check("ImmSrcD", ImmSrcD, InstrD[15:14]);
    check("ALUSrcE", ALUSrcE, e_s.as);
    check("ALUControlE", ALUControlE, e_s.ac);
    check("MemtoRegE", MemtoRegE, e_s.mr);
    check("BranchTakenE", BranchTakenE, e_s.br & cx);
    check("MemWriteM", MemWriteM, m_s.mw);
    check("RegWriteM", RegWriteM, m_s.rw);
    check("RegWriteW", RegWriteW, w_s.rw);
    check("MemtoRegW", MemtoRegW, w_s.mr);
    check("PCSrcW", PCSrcW, w_s.pcs);
    check("PCWrPendingF", PCWrPendingF, d.pcs | e_s.pcs | m_s.pcs);
  endtask

  task automatic advance();
    ctl_t d;
    logic cx;
    d  = decode(InstrD);
    cx = cond_ok(e_s.cond, flags_s);
    if (e_s.fw[1] && cx) flags_s[3:2] = ALUFlags[3:2];
    if (e_s.fw[0] && cx) flags_s[1:0] = ALUFlags[1:0];
    w_s     = m_s;
    m_s     = '0;
    m_s.rw  = e_s.rw & cx;
    m_s.mw  = e_s.mw & cx;
    m_s.pcs = e_s.pcs & cx;
    m_s.mr  = e_s.mr;
    if (FlushE) begin
      d.rw = 1'b0; d.mw = 1'b0; d.pcs = 1'b0; d.br = 1'b0; d.fw = 2'b00;
    end
    e_s = d;
  endtask

  // Called away from a rising edge; returns on the following falling edge
  task automatic cycle(input logic [19:0] ins, input logic [3:0] af, input logic fl);
    InstrD   = ins;
    ALUFlags = af;
    FlushE   = fl;
    #1 check_all();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_ALUSrcE"}, ALUSrcE, 0);
    check({pre, "_ALUControlE"}, ALUControlE, 0);
    check({pre, "_BranchTakenE"}, BranchTakenE, 0);
    check({pre, "_MemtoRegE"}, MemtoRegE, 0);
    check({pre, "_MemWriteM"}, MemWriteM, 0);
    check({pre, "_RegWriteM"}, RegWriteM, 0);
    check({pre, "_RegWriteW"}, RegWriteW, 0);
    check({pre, "_MemtoRegW"}, MemtoRegW, 0);
    check({pre, "_PCSrcW"}, PCSrcW, 0);
    check({pre, "_PCWrPendingF"}, PCWrPendingF, decode(InstrD).pcs);
  endtask

  // Called on a falling edge; asserts reset mid-phase, holds across one rising edge
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_zero("rst");
    e_s = '0; m_s = '0; w_s = '0; flags_s = '0;
    @(posedge clk);
    @(negedge clk);
    #1 check_zero("rsthold");
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [19:0] ins;
    reset    = 1'b0;
    InstrD   = NOP;
    ALUFlags = 4'h0;
    FlushE   = 1'b0;
    e_s = '0; m_s = '0; w_s = '0; flags_s = '0;
    @(negedge clk);
    do_reset();

    cycle(ADD_R1, 4'h0, 1'b0);
    check("r28_ALUControlE", ALUControlE, 2'b00);
    cycle(NOP, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r28_RegWriteW", RegWriteW, 1);
    check("r28_MemtoRegW", MemtoRegW, 0);
    check("r28_PCSrcW", PCSrcW, 0);

    cycle(SUBS, 4'h0, 1'b0);
    cycle(BEQ, 4'b0100, 1'b0);
    check("r29_BranchTakenE", BranchTakenE, 1);
    cycle(NOP, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r29_PCSrcW", PCSrcW, 1);

    cycle(SUBS, 4'h0, 1'b0);
    cycle(BEQ, 4'b0000, 1'b0);
    check("r30_BranchTakenE", BranchTakenE, !COND_ON);
    cycle(NOP, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r30_PCSrcW", PCSrcW, !COND_ON);

    cycle(LDR_PC, 4'h0, 1'b0);
    check("r31_PCWrPendingF_e", PCWrPendingF, 1);
    cycle(NOP, 4'h0, 1'b0);
    check("r31_PCWrPendingF_m", PCWrPendingF, 1);
    cycle(NOP, 4'h0, 1'b0);
    check("r31_PCWrPendingF_w", PCWrPendingF, 0);
    check("r31_MemtoRegW", MemtoRegW, 1);
    check("r31_RegWriteW", RegWriteW, 1);
    check("r31_PCSrcW", PCSrcW, 1);

    cycle(STR, 4'h0, 1'b1);
    cycle(NOP, 4'h0, 1'b0);
    check("r32_flush_MemWriteM", MemWriteM, 0);
    cycle(NOP, 4'h0, 1'b0);
    check("r32_flush_RegWriteW", RegWriteW, 0);
    cycle(STR, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r32_MemWriteM", MemWriteM, 1);

    cycle(SUBS, 4'h0, 1'b0);
    cycle(NOP, 4'b0100, 1'b1);
    cycle(BEQ, 4'h0, 1'b0);
    check("r20_BranchTakenE", BranchTakenE, 1);

    cycle(ADD_R1, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r33_RegWriteM_pre", RegWriteM, 1);
    do_reset();
    cycle(BEQ, 4'h0, 1'b0);
    check("r33_flags_cleared", BranchTakenE, !COND_ON);
    cycle(SUBS, 4'h0, 1'b0);
    cycle(ADDNE, 4'b0100, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    cycle(NOP, 4'h0, 1'b0);
    check("r33_addne_RegWriteW", RegWriteW, !COND_ON);

    for (int i = 0; i < 600; i++) begin
      ins[19:16] = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
      ins[15:14] = 2'($urandom_range(0, 3));
      ins[13:8]  = 6'($urandom_range(0, 63));
      ins[7:4]   = 4'($urandom_range(0, 15));
      ins[3:0]   = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(ins, 4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
